// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_local_ram.sv
// Single-port synchronous RAM, WORDS x 32, write-enable and registered read.
module dmem_local_ram
  import dmem_responder_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]        d,
  output logic [DATA_W-1:0]        q
);

  logic [DATA_W-1:0] mem [WORDS];

  // Read port only updates when enabled so a held result survives stalls.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: local RAM below LOCAL_WORDS, external req/ack bus above,
// with a timeout that returns ERR_DATA and latches a sticky error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                LOCAL_WORDS = 1024,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              busy,
  input  logic              hold,
  input  logic              clear,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              timeout_err
);

  localparam int               IDX_W   = $clog2(LOCAL_WORDS);
  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result_r;
  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] ram_q;
  logic              q_from_ram;

  logic req, rd, local_hit, done_load, ram_we, ram_re;

  assign req       = re | we;
  assign rd        = re & ~we;
  assign local_hit = (addr < ADDR_W'(LOCAL_WORDS));
  assign busy      = req & ~local_hit & (state != DONE);
  assign done_load = (state == DONE) & ~hold & rd & ~local_hit;
  assign ram_we    = we & local_hit;
  assign ram_re    = rd & local_hit & ~hold & ~clear & ~done_load;

  dmem_local_ram #(
    .WORDS(LOCAL_WORDS)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .re  (ram_re),
    .addr(addr[IDX_W-1:0]),
    .d   (data),
    .q   (ram_q)
  );

  // q is either the RAM's read register or our own; a flag picks which one is live.
  assign q = q_from_ram ? ram_q : q_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r        <= '0;
      q_from_ram <= 1'b0;
    end else if (done_load) begin
      q_r        <= result_r;
      q_from_ram <= 1'b0;
    end else if (clear) begin
      q_r        <= '0;
      q_from_ram <= 1'b0;
    end else if (ram_re) begin
      q_from_ram <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      result_r    <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !local_hit) begin
            bus_addr  <= addr;
            bus_wdata <= data;
            bus_we    <= we;
            bus_req   <= 1'b1;
            cnt       <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            result_r <= bus_rdata;
            state    <= DONE;
          end else if (cnt == CNT_MAX) begin
            bus_req     <= 1'b0;
            result_r    <= ERR_DATA;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: local table vectors plus external bus sequences.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] q;
  logic        busy;
  logic        hold = 1'b0;
  logic        clear = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .LOCAL_WORDS(1024),
    .TIMEOUT    (8),
    .ERR_DATA   (32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .we         (we),
    .re         (re),
    .data       (data),
    .q          (q),
    .busy       (busy),
    .hold       (hold),
    .clear      (clear),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one external access; the ack is driven n cycles after bus_req rises.
  task automatic ext_txn(input logic w, input logic r, input logic clr, input logic give_ack,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                         input int n, output int busy_cyc, output int req_cyc,
                         output logic fields_ok);
    int since;
    bit done;
    busy_cyc = 0; req_cyc = 0; fields_ok = 1'b1; since = -1; done = 0;
    we = w; re = r; addr = a; data = d; clear = clr;
    for (int c = 0; c < 100 && !done; c++) begin
      bus_ack   = give_ack && bus_req && (since == n);
      bus_rdata = bus_ack ? rd : 32'h0;
      @(negedge clk);
      if (busy) busy_cyc++;
      if (bus_req) begin
        req_cyc++;
        if (bus_addr !== a || bus_we !== w || (w && bus_wdata !== d)) fields_ok = 1'b0;
      end
      if (!busy && busy_cyc > 0) done = 1;
      @(posedge clk); #1;
      if (bus_req) since++;
    end
    bus_ack = 1'b0; bus_rdata = '0;
    we = 1'b0; re = 1'b0; clear = 1'b0; addr = '0; data = '0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ext_txn_bound: got no completion, expected completion within 100 cycles");
    end
  endtask

  typedef struct {
    logic        we, re, hold, clear;
    logic [31:0] addr, data, exp_q;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bc, rc;
    logic ok;

    //            we    re    hold  clear addr         data          exp_q         busy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd5,    32'h12345678, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd10,   32'hAAAA5555, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1023, 32'h0F0F0F0F, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd5,    32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd10,   32'h0,        32'hAAAA5555, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1023, 32'h0,        32'h0F0F0F0F, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd5,    32'h0,        32'h0F0F0F0F, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd5,    32'h0,        32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd5,    32'h0,        32'h12345678, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd10,   32'h11112222, 32'h12345678, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd10,   32'h0,        32'h11112222, 1'b0};

    #1;
    check("rst_q", q, 32'h0);
    check("rst_bus_req", {31'b0, bus_req}, 32'h0);
    check("rst_bus_we", {31'b0, bus_we}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; re = vecs[i].re; hold = vecs[i].hold; clear = vecs[i].clear;
      addr = vecs[i].addr; data = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
      @(posedge clk); #1;
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
    end
    we = 1'b0; re = 1'b0; hold = 1'b0; clear = 1'b0; addr = '0; data = '0;
    @(posedge clk); #1;

    ext_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h00100000, 32'h0, 32'hCAFEF00D, 3, bc, rc, ok);
    check("extrd_busy_cycles", bc, 32'd5);
    check("extrd_req_cycles", rc, 32'd4);
    check("extrd_fields", {31'b0, ok}, 32'h1);
    check("extrd_q", q, 32'hCAFEF00D);
    check("extrd_bus_req_low", {31'b0, bus_req}, 32'h0);

    ext_txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h00200000, 32'hA5A5A5A5, 32'h0, 1, bc, rc, ok);
    check("extwr_busy_cycles", bc, 32'd3);
    check("extwr_fields", {31'b0, ok}, 32'h1);
    check("extwr_q_unchanged", q, 32'hCAFEF00D);

    check("pre_timeout_err", {31'b0, timeout_err}, 32'h0);
    ext_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h00300000, 32'h0, 32'h0, 0, bc, rc, ok);
    check("tmo_busy_cycles", bc, 32'd10);
    check("tmo_req_cycles", rc, 32'd9);
    check("tmo_q", q, 32'hDEADBEEF);
    check("tmo_err", {31'b0, timeout_err}, 32'h1);

    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = '0;
    @(posedge clk); #1;
    check("late_ack_q", q, 32'hDEADBEEF);
    check("late_ack_bus_req", {31'b0, bus_req}, 32'h0);

    ext_txn(1'b0, 1'b1, 1'b1, 1'b1, 32'h00000400, 32'h0, 32'h00000042, 2, bc, rc, ok);
    check("clr_busy_cycles", bc, 32'd4);
    check("clr_fields", {31'b0, ok}, 32'h1);
    check("clr_q", q, 32'h00000042);
    check("clr_err_sticky", {31'b0, timeout_err}, 32'h1);

    re = 1'b1; addr = 32'h00500000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("prerst_bus_req", {31'b0, bus_req}, 32'h1);
    reset = 1'b0;
    #1;
    check("arst_bus_req", {31'b0, bus_req}, 32'h0);
    check("arst_q", q, 32'h0);
    check("arst_bus_addr", bus_addr, 32'h0);
    check("arst_timeout_err", {31'b0, timeout_err}, 32'h0);
    re = 1'b0; addr = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    ext_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h00600000, 32'h0, 32'h0BADC0DE, 2, bc, rc, ok);
    check("postrst_busy_cycles", bc, 32'd4);
    check("postrst_q", q, 32'h0BADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the CPU MEM-stage data-memory interface: addr/we/re/data in, q/busy out, with hold/clear.
- Words below LOCAL_WORDS are served from internal single-cycle RAM with no wait states.
- All other addresses become one transaction on an external req/ack word bus with variable latency. busy is raised until that transaction completes.
- Sits between the CPU core and the external memory/IO fabric.

Parameters:
- LOCAL_WORDS, 1024: number of 32-bit words in the local RAM. Must be a power of 2. Local range is word address 0..LOCAL_WORDS-1.
- TIMEOUT, 255: maximum number of cycles to wait for bus_ack before the transaction is aborted.
- ERR_DATA, 32'hDEADBEEF: value returned on q for a read that timed out.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  32  word address from CPU MEM stage
- we  in  1  write request
- re  in  1  read request
- data  in  32  write data
- q  out  32  read data, registered, valid in the CPU WB stage
- busy  out  1  combinational: request not yet completed
- hold  in  1  freeze q and the FSM
- clear  in  1  synchronously zero q
- bus_req  out  1  external bus request
- bus_we  out  1  external write strobe
- bus_addr  out  32  external word address
- bus_wdata  out  32  external write data
- bus_rdata  in  32  external read data
- bus_ack  in  1  external completion, one-cycle pulse
- timeout_err  out  1  sticky flag: a bus transaction timed out

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. q=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, timeout_err=0, cycle counter=0. Local RAM contents are not reset.
- Request definitions:
  - req = re|we.
  - If re and we are both 1, the access is a write.
  - local = (addr < LOCAL_WORDS).
- Local access: busy=0.
  - Write: RAM[addr] <= data at the edge.
  - Read: q <= RAM[addr] at the edge, so q is valid one cycle later.
- External access, FSM states IDLE, BUS, DONE:
  - IDLE: req & !local drives busy=1. At the next edge, register addr, data and we onto the bus outputs, set bus_req=1, clear the counter, go to BUS.
  - BUS: busy=1 and bus_req stays 1. bus_addr, bus_wdata and bus_we are stable for the whole transaction.
    - bus_ack=1: bus_req <= 0, capture bus_rdata into result_r, go to DONE.
    - Otherwise the counter increments. When counter==TIMEOUT with no ack: bus_req <= 0, result_r <= ERR_DATA, timeout_err <= 1, go to DONE.
    - A bus_ack arriving after a timeout, while not in BUS, is ignored.
  - DONE: busy=0. At the edge, if re was set, q <= result_r. Go to IDLE.
- Latency:
  - Local access: 0 wait cycles.
  - External access: busy asserted for N+2 cycles, where bus_ack arrives N cycles after bus_req rises (N≥1).
  - Back-to-back external requests: IDLE is re-entered after DONE, so the new request sees busy=1 in the following cycle.
- busy = req & !local & (state != DONE). When req=0, busy=0.
- clear=1: q <= 0 at the edge.
  - Has priority over hold and over a q load, except a q load in DONE.
  - Does not abort or affect a bus transaction. The CPU asserts clear on every busy cycle.
- hold=1: q keeps its value. The FSM does not leave DONE, and busy stays 0.
- Request withdrawn (req=0) while in BUS: the transaction still completes. In DONE the result is discarded and the FSM returns to IDLE.
- Reset mid-transaction: bus_req drops immediately and the transaction is abandoned. The external side must tolerate this.
- Widths: address compare is unsigned 32-bit. The local RAM is indexed by addr[$clog2(LOCAL_WORDS)-1:0]. The counter is $clog2(TIMEOUT+1) bits.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, BUS=2'd1, DONE=2'd2
  - ERR_DATA default
  - bus request/response field widths
- Sub-module dmem_local_ram: single-port synchronous RAM, LOCAL_WORDS×32, with we, addr, d, q and a registered read. The responder muxes its output into q.

Test Plan:
- Local path: write addr=5 data=32'h12345678, then read addr=5. busy stays 0 throughout, and q=32'h12345678 the cycle after the read edge.
- External read: re, addr=32'h00100000, bus_ack after 3 cycles with bus_rdata=32'hCAFEF00D. busy high for 5 cycles, bus_addr stable, q=32'hCAFEF00D after the DONE edge.
- External write: we, addr=32'h00200000, data=32'hA5A5A5A5, ack after 1 cycle. bus_we=1, bus_wdata=32'hA5A5A5A5, busy for 3 cycles, q unchanged.
- Timeout: re external with no ack, TIMEOUT=8. Transaction ends via the timeout path, q=32'hDEADBEEF, timeout_err=1 and stays set. A late ack is ignored.
- clear during busy: clear=1 every BUS cycle, then ack with 32'h00000042. The bus transaction is unaffected and q=32'h00000042 after DONE.
- Async reset: drop reset during BUS. bus_req=0 and q=0 immediately, state IDLE. A new external read afterwards completes normally.
